bsg_tx_scheduler: RTL and testbench

Transmit scheduler for the BSG bit-stream generator. Host logic pushes bytes into an internal FIFO. The block then drives the BSG register port to preload the two ping-pong data registers (DATA0/DATA1), set TXENABLE, and refill each data register as the modulator consumes it. When the stream drains or is aborted, it clears TXENABLE and raises a completion interrupt. It sits between the host datapath and the BSG register interface, in the SYS_CLK domain.

---
 rtl/bsg_pkg.sv | 26 ++
 rtl/bsg_tx_fifo.sv | 63 ++++++
 rtl/bsg_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_bsg_tx_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_pkg.sv
// Shared types and constants for the BSG transmit scheduler.
// Holds the FSM state encoding, default register map and CTRL register layout.
package bsg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD0,
    S_PRELOAD1,
    S_ENABLE,
    S_STREAM,
    S_DISABLE
  } state_e;

  localparam logic [7:0] ADDR_CTRL_DEF  = 8'h00;
  localparam logic [7:0] ADDR_DATA0_DEF = 8'h01;
  localparam logic [7:0] ADDR_DATA1_DEF = 8'h02;

  localparam int CTRL_TXENABLE = 0;
  localparam int CTRL_INTMSK   = 1;
  localparam int CTRL_INTFLAG  = 2;
  localparam int CTRL_STATUS   = 3;

  localparam logic [7:0] CTRL_WR_ENABLE = 8'(1 << CTRL_TXENABLE);
  localparam logic [7:0] CTRL_WR_IDLE   = 8'h00;

endpackage

// File: rtl/bsg_tx_fifo.sv
// Byte FIFO with first-word-fall-through read data and a registered fill level.
// flush empties the FIFO and wins over a push/pop in the same cycle.
module bsg_tx_fifo #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          SYS_CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/bsg_tx_scheduler.sv
// Transmit scheduler: preloads the BSG ping-pong data registers, enables TX,
// refills slots as the modulator consumes them, then disables TX and raises done_irq.
module bsg_tx_scheduler
  import bsg_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] ADDR_CTRL  = ADDR_CTRL_DEF,
  parameter logic [7:0] ADDR_DATA0 = ADDR_DATA0_DEF,
  parameter logic [7:0] ADDR_DATA1 = ADDR_DATA1_DEF,
  localparam int        LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          SYS_CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          fifo_full,
  output logic [LW-1:0] fifo_level,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done_irq,
  input  logic          irq_clr,
  output logic [7:0]    bsg_addr,
  output logic [7:0]    bsg_wdata,
  output logic          bsg_wr,
  input  logic          bsg_ready,
  input  logic          byte_taken
);

  state_e     state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0] in_flight_q, in_flight_d, pending_q, pending_d, fl_tk, pd_tk;
  logic       slot_q, slot_d, abort_q, abort_d, done_q, done_d, busy_q, busy_d;
  logic       pop, flush, fl_inc, pd_dec, wr_done, tk, abort_req, fifo_empty;
  logic [7:0] fifo_rdata;

  bsg_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .SYS_CLK  (SYS_CLK),
    .RST_N    (RST_N),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (flush),
    .rdata    (fifo_rdata),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wr_done   = wr_q & bsg_ready;
  assign tk        = byte_taken & (state_q != S_IDLE);
  assign abort_req = (abort | abort_q) & (state_q != S_IDLE) & (state_q != S_DISABLE);
  // Counters after this cycle's byte_taken, before any refill completion is credited.
  assign fl_tk = (tk && in_flight_q != 2'd0) ? in_flight_q - 2'd1 : in_flight_q;
  assign pd_tk = (tk && pending_q != 2'd2) ? pending_q + 2'd1 : pending_q;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_done ? 1'b0 : wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    slot_d  = slot_q;
    abort_d = abort_q;
    done_d  = done_q & ~irq_clr;
    pop     = 1'b0;
    flush   = 1'b0;
    fl_inc  = 1'b0;
    pd_dec  = 1'b0;
    case (state_q)
      S_IDLE: if (start && !fifo_empty) begin
        pop = 1'b1; wr_d = 1'b1; addr_d = ADDR_DATA0; wdata_d = fifo_rdata;
        state_d = S_PRELOAD0;
      end
      S_PRELOAD0: if (wr_done) begin
        fl_inc = 1'b1;
        wr_d   = 1'b1;
        if (!fifo_empty) begin
          pop = 1'b1; addr_d = ADDR_DATA1; wdata_d = fifo_rdata;
          state_d = S_PRELOAD1;
        end else begin
          addr_d = ADDR_CTRL; wdata_d = CTRL_WR_ENABLE;
          state_d = S_ENABLE;
        end
      end
      S_PRELOAD1: if (wr_done) begin
        fl_inc = 1'b1; wr_d = 1'b1; addr_d = ADDR_CTRL; wdata_d = CTRL_WR_ENABLE;
        state_d = S_ENABLE;
      end
      S_ENABLE: if (wr_done) begin
        slot_d  = 1'b0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (wr_done) begin
          slot_d = ~slot_q; pd_dec = 1'b1; fl_inc = 1'b1;
        end else if (!wr_q && pd_tk != 2'd0 && !fifo_empty) begin
          pop = 1'b1; wr_d = 1'b1; wdata_d = fifo_rdata;
          addr_d = slot_q ? ADDR_DATA1 : ADDR_DATA0;
        end else if (!wr_q && fl_tk == 2'd0 && fifo_empty) begin
          wr_d = 1'b1; addr_d = ADDR_CTRL; wdata_d = CTRL_WR_IDLE;
          state_d = S_DISABLE;
        end
      end
      S_DISABLE: if (wr_done) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_flight_d = (fl_inc && fl_tk != 2'd2) ? fl_tk + 2'd1 : fl_tk;
    pending_d   = (pd_dec && pd_tk != 2'd0) ? pd_tk - 2'd1 : pd_tk;
    if (state_q == S_DISABLE && wr_done) begin
      in_flight_d = 2'd0;
      pending_d   = 2'd0;
    end

    // Abort waits for the bus to free up, then overrides whatever the state chose.
    if (abort_req) begin
      if (!wr_q || wr_done) begin
        pop = 1'b0; flush = 1'b1; abort_d = 1'b0;
        wr_d = 1'b1; addr_d = ADDR_CTRL; wdata_d = CTRL_WR_IDLE;
        state_d = S_DISABLE;
      end else begin
        abort_d = 1'b1;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      in_flight_q <= '0;
      pending_q   <= '0;
      slot_q      <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_flight_q <= in_flight_d;
      pending_q   <= pending_d;
      slot_q      <= slot_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bsg_wr    = wr_q;
  assign bsg_addr  = addr_q;
  assign bsg_wdata = wdata_q;
  assign busy      = busy_q;
  assign done_irq  = done_q;

endmodule

// File: tb/tb_bsg_tx_scheduler.sv
// Directed bench for bsg_tx_scheduler: preload/refill sequencing, stalls, FIFO limits,
// abort, irq priority and asynchronous reset.
module tb_bsg_tx_scheduler;

  logic       SYS_CLK = 1'b0;
  logic       RST_N;
  logic       push, start, abort, irq_clr, bsg_ready, byte_taken;
  logic [7:0] push_data;
  logic       fifo_full, busy, done_irq, bsg_wr;
  logic [3:0] fifo_level;
  logic [7:0] bsg_addr, bsg_wdata;

  int checks = 0;
  int errors = 0;
  logic [15:0] wlog [$];

  bsg_tx_scheduler dut (
    .SYS_CLK   (SYS_CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (push_data),
    .fifo_full (fifo_full),
    .fifo_level(fifo_level),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done_irq  (done_irq),
    .irq_clr   (irq_clr),
    .bsg_addr  (bsg_addr),
    .bsg_wdata (bsg_wdata),
    .bsg_wr    (bsg_wr),
    .bsg_ready (bsg_ready),
    .byte_taken(byte_taken)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Completed bus writes, {addr, data}.
  always @(negedge SYS_CLK) begin
    if (RST_N === 1'b1 && bsg_wr && bsg_ready) wlog.push_back({bsg_addr, bsg_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] bus();
    return {bsg_wr, bsg_addr, bsg_wdata};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge SYS_CLK);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    push = 1'b1; push_data = b; step(1); push = 1'b0;
  endtask

  task automatic pulse_taken();
    byte_taken = 1'b1; step(1); byte_taken = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [15:0] exp);
    if (idx < wlog.size()) chk(tag, wlog[idx], exp);
    else chk(tag, 32'hdead_beef, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; push = 1'b0; push_data = '0; start = 1'b0; abort = 1'b0;
    irq_clr = 1'b0; bsg_ready = 1'b1; byte_taken = 1'b0;
    step(2);
    chk("rst_bus", bus(), 17'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done_irq, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_full", fifo_full, 1'b0);
    RST_N = 1'b1;
    step(1);

    // Three-byte stream with one refill
    wlog.delete();
    push_byte(8'hA5); push_byte(8'h3C); push_byte(8'h0F);
    chk("t1_level", fifo_level, 4'd3);
    start = 1'b1; step(1); start = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_data0", bus(), {1'b1, 8'h01, 8'hA5});
    step(1);
    chk("t1_data1", bus(), {1'b1, 8'h02, 8'h3C});
    step(1);
    chk("t1_enable", bus(), {1'b1, 8'h00, 8'h01});
    step(1);
    chk("t1_bus_idle", bsg_wr, 1'b0);
    chk("t1_level_after", fifo_level, 4'd1);
    pulse_taken();
    chk("t1_refill", bus(), {1'b1, 8'h01, 8'h0F});
    step(1);
    pulse_taken();
    chk("t1_no_disable_yet", bsg_wr, 1'b0);
    pulse_taken();
    chk("t1_disable", bus(), {1'b1, 8'h00, 8'h00});
    chk("t1_done_early", done_irq, 1'b0);
    step(1);
    chk("t1_done", done_irq, 1'b1);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_nwrites", wlog.size(), 5);
    irq_clr = 1'b1; step(1); irq_clr = 1'b0;
    chk("t1_irq_clr", done_irq, 1'b0);

    // Single byte: no DATA1 write
    wlog.delete();
    push_byte(8'h77);
    start = 1'b1; step(1); start = 1'b0;
    chk("t2_data0", bus(), {1'b1, 8'h01, 8'h77});
    step(1);
    chk("t2_enable", bus(), {1'b1, 8'h00, 8'h01});
    step(1);
    chk("t2_bus_idle", bsg_wr, 1'b0);
    pulse_taken();
    chk("t2_disable", bus(), {1'b1, 8'h00, 8'h00});
    step(1);
    chk("t2_done", done_irq, 1'b1);
    chk("t2_nwrites", wlog.size(), 3);
    irq_clr = 1'b1; step(1); irq_clr = 1'b0;

    // Stall on DATA1 with two byte_taken pulses during the stall
    wlog.delete();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    bsg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      byte_taken = (i == 1 || i == 3);
      step(1);
      chk($sformatf("t3_stall%0d", i), bus(), {1'b1, 8'h02, 8'h22});
    end
    byte_taken = 1'b0; bsg_ready = 1'b1;
    step(1);
    chk("t3_enable", bus(), {1'b1, 8'h00, 8'h01});
    step(6);
    chk("t3_nwrites", wlog.size(), 5);
    chk_log("t3_w0", 0, 16'h0111);
    chk_log("t3_w1", 1, 16'h0222);
    chk_log("t3_w2", 2, 16'h0001);
    chk_log("t3_w3", 3, 16'h0133);
    chk_log("t3_w4", 4, 16'h0244);
    pulse_taken(); pulse_taken();
    wait_idle(20);
    chk("t3_done", done_irq, 1'b1);
    irq_clr = 1'b1; step(1); irq_clr = 1'b0;

    // FIFO full / drop, simultaneous push+pop, abort during preload
    wlog.delete();
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    chk("t4_level8", fifo_level, 4'd8);
    chk("t4_full", fifo_full, 1'b1);
    push_byte(8'hEE);
    chk("t4_drop", fifo_level, 4'd8);
    start = 1'b1; step(1); start = 1'b0;
    chk("t4_data0", bus(), {1'b1, 8'h01, 8'h10});
    chk("t4_level7", fifo_level, 4'd7);
    push_byte(8'h99);
    chk("t4_data1", bus(), {1'b1, 8'h02, 8'h11});
    chk("t4_pushpop", fifo_level, 4'd7);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("t4_abort_disable", bus(), {1'b1, 8'h00, 8'h00});
    chk("t4_flushed", fifo_level, 4'd0);
    step(1);
    chk("t4_done", done_irq, 1'b1);
    chk("t4_busy_low", busy, 1'b0);
    chk("t4_nwrites", wlog.size(), 3);

    // Abort in STREAM with 4 queued and a stalled refill; irq_clr collides with set
    wlog.delete();
    for (int i = 0; i < 6; i++) push_byte(8'h20 + 8'(i));
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    chk("t5_level4", fifo_level, 4'd4);
    bsg_ready = 1'b0;
    pulse_taken();
    chk("t5_refill", bus(), {1'b1, 8'h01, 8'h22});
    abort = 1'b1; step(1); abort = 1'b0;
    chk("t5_hold", bus(), {1'b1, 8'h01, 8'h22});
    chk("t5_level3", fifo_level, 4'd3);
    bsg_ready = 1'b1;
    step(1);
    chk("t5_disable", bus(), {1'b1, 8'h00, 8'h00});
    chk("t5_flushed", fifo_level, 4'd0);
    irq_clr = 1'b1; step(1); irq_clr = 1'b0;
    chk("t5_set_wins", done_irq, 1'b1);
    chk("t5_busy_low", busy, 1'b0);
    irq_clr = 1'b1; step(1); irq_clr = 1'b0;
    chk("t5_cleared", done_irq, 1'b0);

    // Asynchronous reset mid-refill
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    bsg_ready = 1'b0;
    pulse_taken();
    chk("t6_refill", bsg_wr, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_rst_wr", bsg_wr, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_level", fifo_level, 4'd0);
    step(2);
    RST_N = 1'b1; bsg_ready = 1'b1;
    step(1);
    wlog.delete();
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    chk("t6_empty_start_wr", bsg_wr, 1'b0);
    chk("t6_empty_start_busy", busy, 1'b0);
    chk("t6_no_writes", wlog.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
